// File: rtl/dsp_chain_3_fp16_sop2_result_drain_8.sv
// dsp_chain_3_fp16_sop2_result_drain_8: two-frame buffer serializing wide result frames into lane words
module dsp_chain_3_fp16_sop2_result_drain_8 #(
  parameter int NUM_LANES = 8,
  parameter int LANE_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [NUM_LANES*LANE_W-1:0]  in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [LANE_W-1:0]            out_data,
  output logic [$clog2(NUM_LANES)-1:0] out_lane,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [15:0]                  frames_out
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int FW = NUM_LANES * LANE_W;
  logic [FW-1:0] r_slot [2];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_cnt;
  logic [LW-1:0] r_lane;
  logic [15:0]   r_frames;
  logic          w_push;
  logic          w_beat;
  logic          w_lane_last;
  logic          w_last_beat;
  // handshakes and head-of-buffer lane selection, all from registered state
  always_comb begin
    in_ready    = (r_cnt != 2'd2) && !reset;
    out_valid   = (r_cnt != 2'd0) && !reset;
    w_lane_last = r_lane == LW'(NUM_LANES - 1);
    out_last    = out_valid && w_lane_last;
    out_lane    = reset ? '0 : r_lane;
    out_data    = r_slot[r_rd][int'(r_lane) * LANE_W +: LANE_W];
    w_push      = in_valid && in_ready;
    w_beat      = out_valid && out_ready;
    w_last_beat = w_beat && w_lane_last;
    frames_out  = r_frames;
  end
  // frame storage is written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_slot[r_wr] <= in_data;
  end
  // pointers, occupancy, lane progress and drained-frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
      r_lane   <= '0;
      r_frames <= 16'd0;
    end else begin
      if (w_push) r_wr <= !r_wr;
      if (w_beat) r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
      if (w_last_beat) begin
        r_rd     <= !r_rd;
        r_frames <= r_frames + 16'd1;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_last_beat};
    end
  end
endmodule

// File: tb/tb_dsp_chain_3_fp16_sop2_result_drain_8.sv
// tb_dsp_chain_3_fp16_sop2_result_drain_8: self-checking bench for the result drain
module tb_dsp_chain_3_fp16_sop2_result_drain_8;
  localparam int NL = 8;
  localparam int LW = 32;
  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [255:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic [31:0]    out_data;
  logic [2:0]     out_lane;
  logic           out_last;
  logic           out_ready;
  logic [15:0]    frames_out;
  int             errors = 0;
  int             checks = 0;
  logic [15:0]    exp_frames;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        e_last;
    logic [2:0]  e_lane;
    logic [31:0] e_data;
  } vec_t;

  dsp_chain_3_fp16_sop2_result_drain_8 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .out_ready(out_ready),
    .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] f;
    for (int k = 0; k < NL; k++) f[k*LW +: LW] = base + 32'(k);
    return f;
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int k = 0; k < NL; k++) f[k*LW +: LW] = $urandom;
    return f;
  endfunction

  // Reference: a word queue fed whole frames on accepted pushes, at most two frames resident
  task automatic run_stream(input int n, input bit stall, input bit rnd, output int span);
    logic [31:0]  q[$];
    logic [255:0] nxt;
    int pushed = 0, mlane = 0, mocc = 0, drained = 0, cyc = 0, first = -1, last = -1;
    bit p, b;
    nxt = rnd ? rand_frame() : pat(32'hA000_0000);
    while (drained < n && cyc < n * 40 + 100) begin
      in_valid  = (pushed < n) && (!rnd || 1'($urandom_range(0, 1)));
      in_data   = nxt;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("s_in_ready", in_ready, mocc < 2);
      chk("s_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("s_data", out_data, q[0]);
        chk("s_lane", out_lane, mlane);
        chk("s_last", out_last, mlane == NL - 1);
      end
      p = in_valid && (mocc < 2);
      b = (q.size() > 0) && out_ready;
      tick();
      cyc++;
      if (b) begin
        if (first < 0) first = cyc;
        last = cyc;
        void'(q.pop_front());
        mlane++;
        if (mlane == NL) begin
          mlane = 0;
          mocc--;
          drained++;
          exp_frames++;
        end
      end
      if (p) begin
        for (int k = 0; k < NL; k++) q.push_back(nxt[k*LW +: LW]);
        mocc++;
        pushed++;
        nxt = rnd ? rand_frame() : pat(32'hA000_0000 + 32'(pushed * 256));
      end
    end
    chk("s_frames_drained", drained, n);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    span = last - first + 1;
  endtask

  initial begin
    vec_t         tbl[10];
    logic [255:0] fa, fb, fc;
    int           span;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_lane", out_lane, 0);
    tick();
    tick();
    chk("rst_frames", frames_out, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    exp_frames = 16'd0;

    for (int i = 0; i < 10; i++) begin
      tbl[i].iv     = i == 0;
      tbl[i].ordy   = i != 9;
      tbl[i].e_ir   = 1'b1;
      tbl[i].e_ov   = i >= 1 && i <= 8;
      tbl[i].e_lane = (i >= 1 && i <= 8) ? 3'(i - 1) : 3'd0;
      tbl[i].e_last = i == 8;
      tbl[i].e_data = 32'h3C00_0000 + 32'((i >= 1) ? i - 1 : 0);
    end
    in_data = pat(32'h3C00_0000);
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      chk("t_in_ready", in_ready, tbl[i].e_ir);
      chk("t_out_valid", out_valid, tbl[i].e_ov);
      chk("t_out_lane", out_lane, tbl[i].e_lane);
      chk("t_out_last", out_last, tbl[i].e_last);
      if (tbl[i].e_ov) chk("t_out_data", out_data, tbl[i].e_data);
      tick();
    end
    exp_frames++;
    chk("t_frames", frames_out, exp_frames);

    fa = pat(32'h1000_0000);
    fb = pat(32'h2000_0000);
    fc = pat(32'h3000_0000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = fa;
    tick();
    in_data = fb;
    tick();
    in_data = fc;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      chk("hold_data", out_data, fa[31:0]);
      chk("hold_lane", out_lane, 0);
      chk("hold_last", out_last, 0);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < NL; k++) begin
      chk("a_data", out_data, fa[k*LW +: LW]);
      chk("a_lane", out_lane, k);
      if (k == NL - 1) begin
        chk("a_last", out_last, 1);
        chk("a_last_in_ready", in_ready, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("after_pop_in_ready", in_ready, 1);
    for (int k = 0; k < NL; k++) begin
      chk("b_valid", out_valid, 1);
      chk("b_data", out_data, fb[k*LW +: LW]);
      chk("b_lane", out_lane, k);
      tick();
    end
    chk("c_not_accepted", out_valid, 0);
    exp_frames += 16'd2;
    chk("ab_frames", frames_out, exp_frames);

    run_stream(4, 1'b0, 1'b0, span);
    chk("stream_span", span, 32);
    chk("stream_frames", frames_out, exp_frames);

    run_stream(100, 1'b1, 1'b1, span);
    chk("rand_frames", frames_out, exp_frames);

    fa = pat(32'h5000_0000);
    fb = pat(32'h6000_0000);
    fc = pat(32'h7000_0000);
    in_valid  = 1'b1;
    in_data   = fa;
    out_ready = 1'b0;
    tick();
    in_data   = fb;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_lane", out_lane, 3);
    chk("mid_data", out_data, fa[3*LW +: LW]);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_lane", out_lane, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("after_rst_valid", out_valid, 0);
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_frames", frames_out, 0);
    in_valid = 1'b1;
    in_data  = fc;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NL; k++) begin
      chk("z_valid", out_valid, 1);
      chk("z_lane", out_lane, k);
      chk("z_data", out_data, fc[k*LW +: LW]);
      tick();
    end
    chk("z_frames", frames_out, 1);
    chk("z_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
